wb_slave_interface: RTL and testbench

- Wishbone B4 classic-cycle slave. It is the responder counterpart to wb_master_interface.
- Accepts single transfers from the bus matrix and converts them into one-cycle local register read/write strobes.
- Returns ack, err or rty to the master.
- Sits between a bus-matrix slave port and a DSP block's register bank. It lets DSP peripherals be reached by the same master/matrix fabric that carries wb_ram traffic.

---
 rtl/wb_slave_interface.sv | 179 +++++++++++++++++
 tb/tb_wb_slave_interface.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/wb_slave_interface.sv
// wb_slave_interface
//   Wishbone B4 classic-cycle slave that turns single bus transfers into
//   one-cycle local register strobes for a DSP register bank.
//   A transfer ends in exactly one of ack, err or rty.
//
// State table:
//   S_IDLE | waiting for cyc&stb; decodes address/sel/cti and reg_busy
//   S_WAIT | strobe issued, waiting for reg_ready or the timeout
//   S_RESP | one-cycle ack/err/rty pulse; requests are not sampled here
//
// Ports:
//   wb_clk, wb_rst_n        clock, asynchronous active-low reset
//   wb_adr_i/dat_i/sel_i    byte address, write data, byte selects
//   wb_we_i/cyc_i/stb_i     write enable, cycle, strobe
//   wb_cti_i, wb_bte_i      cycle type (3'b111 rejected), burst type (unused)
//   wb_dat_o                read data, holds until the next read ack
//   wb_ack_o/err_o/rty_o    terminations
//   reg_addr/wdata/sel      latched local word address, write data, selects
//   reg_we, reg_re          one-cycle write/read strobes
//   reg_rdata, reg_ready    local read data and completion
//   reg_busy                local side refuses new accesses (answered with rty)
module wb_slave_interface #(
    parameter logic [31:0] BASE_ADDR = 32'hB000_0000,
    parameter int          ADDR_BITS = 4,
    parameter int          WAIT_MAX  = 16
) (
    input  logic                 wb_clk,
    input  logic                 wb_rst_n,
    input  logic [31:0]          wb_adr_i,
    input  logic [31:0]          wb_dat_i,
    input  logic [3:0]           wb_sel_i,
    input  logic                 wb_we_i,
    input  logic                 wb_cyc_i,
    input  logic                 wb_stb_i,
    input  logic [2:0]           wb_cti_i,
    input  logic [1:0]           wb_bte_i,
    output logic [31:0]          wb_dat_o,
    output logic                 wb_ack_o,
    output logic                 wb_err_o,
    output logic                 wb_rty_o,
    output logic [ADDR_BITS-1:0] reg_addr,
    output logic [31:0]          reg_wdata,
    output logic [3:0]           reg_sel,
    output logic                 reg_we,
    output logic                 reg_re,
    input  logic [31:0]          reg_rdata,
    input  logic                 reg_ready,
    input  logic                 reg_busy
);
    localparam int         HI_LSB   = ADDR_BITS + 2;
    localparam logic [7:0] CNT_LAST = 8'(WAIT_MAX - 1);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

    state_t                state_q, state_d;
    logic [7:0]            cnt_q, cnt_d;
    logic                  write_q, write_d;
    logic                  ack_q, ack_d, err_q, err_d, rty_q, rty_d;
    logic [31:0]           dat_q, dat_d;
    logic [ADDR_BITS-1:0]  addr_q, addr_d;
    logic [31:0]           wdata_q, wdata_d;
    logic [3:0]            sel_q, sel_d;
    logic                  we_q, we_d, re_q, re_d;

    logic                  bad_req;
    logic [31:0]           lane_mask;
    logic                  unused_bits;

    assign unused_bits = ^{wb_bte_i, wb_adr_i[1:0]};

    assign bad_req = (wb_adr_i[31:HI_LSB] != BASE_ADDR[31:HI_LSB]) ||
                     (wb_sel_i == 4'h0) || (wb_cti_i == 3'b111);

    // Unselected byte lanes of a read are returned as zero.
    assign lane_mask = {{8{sel_q[3]}}, {8{sel_q[2]}}, {8{sel_q[1]}}, {8{sel_q[0]}}};

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        write_d = write_q;
        ack_d   = 1'b0;
        err_d   = 1'b0;
        rty_d   = 1'b0;
        dat_d   = dat_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        sel_d   = sel_q;
        we_d    = 1'b0;
        re_d    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (wb_cyc_i && wb_stb_i) begin
                    if (bad_req) begin
                        err_d   = 1'b1;
                        state_d = S_RESP;
                    end else if (reg_busy) begin
                        rty_d   = 1'b1;
                        state_d = S_RESP;
                    end else begin
                        addr_d  = wb_adr_i[ADDR_BITS+1:2];
                        sel_d   = wb_sel_i;
                        write_d = wb_we_i;
                        if (wb_we_i) begin
                            wdata_d = wb_dat_i;
                        end
                        we_d    = wb_we_i;
                        re_d    = !wb_we_i;
                        cnt_d   = 8'd0;
                        state_d = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                // Master gave up: drop silently, a late reg_ready lands in IDLE.
                if (!wb_cyc_i) begin
                    state_d = S_IDLE;
                end else if (reg_ready) begin
                    ack_d   = 1'b1;
                    state_d = S_RESP;
                    if (!write_q) begin
                        dat_d = reg_rdata & lane_mask;
                    end
                end else if (cnt_q == CNT_LAST) begin
                    err_d   = 1'b1;
                    state_d = S_RESP;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            S_RESP: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge wb_clk or negedge wb_rst_n) begin
        if (!wb_rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= 8'd0;
            write_q <= 1'b0;
            ack_q   <= 1'b0;
            err_q   <= 1'b0;
            rty_q   <= 1'b0;
            dat_q   <= 32'd0;
            addr_q  <= '0;
            wdata_q <= 32'd0;
            sel_q   <= 4'd0;
            we_q    <= 1'b0;
            re_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            write_q <= write_d;
            ack_q   <= ack_d;
            err_q   <= err_d;
            rty_q   <= rty_d;
            dat_q   <= dat_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            sel_q   <= sel_d;
            we_q    <= we_d;
            re_q    <= re_d;
        end
    end

    assign wb_dat_o  = dat_q;
    assign wb_ack_o  = ack_q;
    assign wb_err_o  = err_q;
    assign wb_rty_o  = rty_q;
    assign reg_addr  = addr_q;
    assign reg_wdata = wdata_q;
    assign reg_sel   = sel_q;
    assign reg_we    = we_q;
    assign reg_re    = re_q;

endmodule

// File: tb/tb_wb_slave_interface.sv
module tb_wb_slave_interface;
    localparam logic [31:0] BASE = 32'hB000_0000;
    localparam int RESP_ACK = 4, RESP_ERR = 2, RESP_RTY = 1;

    logic        wb_clk = 1'b0;
    logic        wb_rst_n = 1'b0;
    logic [31:0] wb_adr_i = '0, wb_dat_i = '0;
    logic [3:0]  wb_sel_i = '0;
    logic        wb_we_i = 1'b0, wb_cyc_i = 1'b0, wb_stb_i = 1'b0;
    logic [2:0]  wb_cti_i = '0;
    logic [1:0]  wb_bte_i = '0;
    logic [31:0] wb_dat_o;
    logic        wb_ack_o, wb_err_o, wb_rty_o;
    logic [3:0]  reg_addr;
    logic [31:0] reg_wdata;
    logic [3:0]  reg_sel;
    logic        reg_we, reg_re;
    logic [31:0] reg_rdata = '0;
    logic        reg_ready = 1'b0, reg_busy = 1'b0;

    wb_slave_interface dut (
        .wb_clk(wb_clk), .wb_rst_n(wb_rst_n),
        .wb_adr_i(wb_adr_i), .wb_dat_i(wb_dat_i), .wb_sel_i(wb_sel_i),
        .wb_we_i(wb_we_i), .wb_cyc_i(wb_cyc_i), .wb_stb_i(wb_stb_i),
        .wb_cti_i(wb_cti_i), .wb_bte_i(wb_bte_i),
        .wb_dat_o(wb_dat_o), .wb_ack_o(wb_ack_o), .wb_err_o(wb_err_o), .wb_rty_o(wb_rty_o),
        .reg_addr(reg_addr), .reg_wdata(reg_wdata), .reg_sel(reg_sel),
        .reg_we(reg_we), .reg_re(reg_re),
        .reg_rdata(reg_rdata), .reg_ready(reg_ready), .reg_busy(reg_busy)
    );

    always #5 wb_clk = ~wb_clk;

    int cyc_cnt = 0;
    always @(posedge wb_clk) cyc_cnt <= cyc_cnt + 1;

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    typedef struct {
        int          kind;
        logic [31:0] dat;
        int          cyc;
    } resp_t;

    typedef struct {
        logic        we;
        logic [3:0]  addr;
        logic [31:0] wdata;
        logic [3:0]  sel;
    } strb_t;

    resp_t resp_q[$];
    strb_t strb_q[$];

    // Local register bank responder: reg_ready follows a strobe after ready_lat
    // cycles; ready_lat < 0 means never.
    int ready_lat = 0;
    int wait_n = 0;
    bit pend = 0;
    always @(negedge wb_clk) begin
        if (reg_we || reg_re) begin
            pend   = 1;
            wait_n = ready_lat;
        end
        if (pend && ready_lat >= 0 && wait_n == 0) begin
            reg_ready = 1'b1;
            pend      = 0;
        end else begin
            reg_ready = 1'b0;
            if (pend && wait_n > 0) wait_n--;
        end
    end

    // Response monitor
    bit prev_resp = 0;
    always @(negedge wb_clk) begin
        logic [2:0] r;
        resp_t e;
        r = {wb_ack_o, wb_err_o, wb_rty_o};
        if (r != 3'b000) begin
            chk("resp_width", {31'd0, prev_resp}, 32'd0);
            if (resp_q.size() == 0) begin
                chk("unexpected_resp", {29'd0, r}, 32'd0);
            end else begin
                e = resp_q.pop_front();
                chk("resp_kind", {29'd0, r}, e.kind);
                chk("resp_cycle", cyc_cnt, e.cyc);
                chk("wb_dat_o", wb_dat_o, e.dat);
            end
        end
        prev_resp = (r != 3'b000);
    end

    // Strobe monitor
    bit prev_strb = 0;
    always @(negedge wb_clk) begin
        strb_t s;
        if (reg_we || reg_re) begin
            chk("strobe_width", {31'd0, prev_strb}, 32'd0);
            if (strb_q.size() == 0) begin
                chk("unexpected_strobe", {30'd0, reg_we, reg_re}, 32'd0);
            end else begin
                s = strb_q.pop_front();
                chk("strobe_kind", {30'd0, reg_we, reg_re}, {30'd0, s.we, !s.we});
                chk("reg_addr", {28'd0, reg_addr}, {28'd0, s.addr});
                chk("reg_sel", {28'd0, reg_sel}, {28'd0, s.sel});
                if (s.we) chk("reg_wdata", reg_wdata, s.wdata);
            end
        end
        prev_strb = reg_we || reg_re;
    end

    task automatic xfer(input logic [31:0] adr, input logic we, input logic [31:0] dat,
                        input logic [3:0] sel, input logic [2:0] cti,
                        input int kind, input int lat, input logic [31:0] exp_dat,
                        input bit strobe, input logic [3:0] exp_addr);
        int n;
        resp_t e;
        strb_t s;
        @(negedge wb_clk);
        e.kind = kind; e.dat = exp_dat; e.cyc = cyc_cnt + lat;
        resp_q.push_back(e);
        if (strobe) begin
            s.we = we; s.addr = exp_addr; s.wdata = dat; s.sel = sel;
            strb_q.push_back(s);
        end
        wb_adr_i = adr; wb_we_i = we; wb_dat_i = dat; wb_sel_i = sel; wb_cti_i = cti;
        wb_cyc_i = 1'b1; wb_stb_i = 1'b1;
        n = 0;
        do begin
            @(negedge wb_clk);
            n++;
        end while (!(wb_ack_o || wb_err_o || wb_rty_o) && n < 60);
        if (n >= 60) begin
            errors++; checks++;
            $display("FAIL xfer_timeout: no termination for adr %h after %0d cycles", adr, n);
        end
        wb_cyc_i = 1'b0; wb_stb_i = 1'b0; wb_we_i = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_dat_o"}, wb_dat_o, 32'd0);
        chk({tag, "_resp"}, {29'd0, wb_ack_o, wb_err_o, wb_rty_o}, 32'd0);
        chk({tag, "_reg_addr"}, {28'd0, reg_addr}, 32'd0);
        chk({tag, "_reg_wdata"}, reg_wdata, 32'd0);
        chk({tag, "_reg_sel"}, {28'd0, reg_sel}, 32'd0);
        chk({tag, "_strobes"}, {30'd0, reg_we, reg_re}, 32'd0);
    endtask

    initial begin
        strb_t s;
        #3;
        check_all_zero("reset");
        repeat (2) @(negedge wb_clk);
        wb_rst_n = 1'b1;

        // adr, we, dat, sel, cti, kind, latency, expected wb_dat_o, strobe, reg_addr
        ready_lat = 0;
        xfer(BASE + 32'h8, 1, 32'hA5A5B6B6, 4'hF, 3'b000, RESP_ACK, 2, 32'h0, 1, 4'd2);
        ready_lat = 3; reg_rdata = 32'hDDCCBBAA;
        xfer(BASE + 32'h4, 0, 32'h0, 4'h2, 3'b000, RESP_ACK, 5, 32'h0000BB00, 1, 4'd1);
        ready_lat = 0;
        xfer(32'h2000_0000, 1, 32'h1111, 4'hF, 3'b000, RESP_ERR, 1, 32'h0000BB00, 0, 4'd0);
        xfer(BASE + 32'hC, 0, 32'h0, 4'h0, 3'b000, RESP_ERR, 1, 32'h0000BB00, 0, 4'd0);
        xfer(BASE + 32'hC, 0, 32'h0, 4'hF, 3'b111, RESP_ERR, 1, 32'h0000BB00, 0, 4'd0);
        reg_busy = 1'b1;
        xfer(BASE + 32'h10, 1, 32'h0F0F0F0F, 4'hF, 3'b000, RESP_RTY, 1, 32'h0000BB00, 0, 4'd0);
        xfer(BASE + 32'h40, 1, 32'h0F0F0F0F, 4'hF, 3'b000, RESP_ERR, 1, 32'h0000BB00, 0, 4'd0);
        reg_busy = 1'b0;
        xfer(BASE + 32'h10, 1, 32'h0F0F0F0F, 4'hF, 3'b000, RESP_ACK, 2, 32'h0000BB00, 1, 4'd4);

        // Burst beats handled as independent transfers
        reg_rdata = 32'h12345678;
        xfer(BASE + 32'h10, 0, 32'h0, 4'hF, 3'b010, RESP_ACK, 2, 32'h12345678, 1, 4'd4);
        reg_rdata = 32'h9ABCDEF0;
        xfer(BASE + 32'h14, 0, 32'h0, 4'hC, 3'b001, RESP_ACK, 2, 32'h9ABC0000, 1, 4'd5);

        // Timeout, and reg_ready arriving on the timeout edge
        ready_lat = -1;
        xfer(BASE + 32'h3C, 0, 32'h0, 4'hF, 3'b000, RESP_ERR, 17, 32'h9ABC0000, 1, 4'd15);
        ready_lat = 15; reg_rdata = 32'h55667788;
        xfer(BASE + 32'h20, 0, 32'h0, 4'h1, 3'b000, RESP_ACK, 17, 32'h00000088, 1, 4'd8);

        // Master drops cyc mid-WAIT: no response, late reg_ready ignored
        ready_lat = 5;
        @(negedge wb_clk);
        s.we = 0; s.addr = 4'd0; s.wdata = 32'h0; s.sel = 4'hF;
        strb_q.push_back(s);
        wb_adr_i = BASE; wb_we_i = 0; wb_sel_i = 4'hF; wb_cti_i = 3'b000;
        wb_cyc_i = 1'b1; wb_stb_i = 1'b1;
        repeat (3) @(negedge wb_clk);
        wb_cyc_i = 1'b0; wb_stb_i = 1'b0;
        repeat (10) @(negedge wb_clk);
        ready_lat = 0;
        xfer(BASE + 32'h3C, 1, 32'h0BADCAFE, 4'h3, 3'b000, RESP_ACK, 2, 32'h00000088, 1, 4'd15);

        // Asynchronous reset mid-WAIT
        ready_lat = -1;
        @(negedge wb_clk);
        s.we = 0; s.addr = 4'd3; s.wdata = 32'h0; s.sel = 4'h3;
        strb_q.push_back(s);
        wb_adr_i = BASE + 32'hC; wb_we_i = 0; wb_sel_i = 4'h3;
        wb_cyc_i = 1'b1; wb_stb_i = 1'b1;
        repeat (4) @(negedge wb_clk);
        #2 wb_rst_n = 1'b0;
        #1 check_all_zero("async_rst");
        wb_cyc_i = 1'b0; wb_stb_i = 1'b0;
        @(negedge wb_clk);
        wb_rst_n = 1'b1;
        ready_lat = 0; reg_rdata = 32'hCAFEF00D;
        xfer(BASE + 32'h18, 0, 32'h0, 4'hF, 3'b000, RESP_ACK, 2, 32'hCAFEF00D, 1, 4'd6);

        repeat (5) @(negedge wb_clk);
        chk("resp_queue_empty", resp_q.size(), 32'd0);
        chk("strobe_queue_empty", strb_q.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: bench did not finish");
        $fatal(1, "global timeout");
    end
endmodule
